// File: rtl/diff_lag_sat.sv
`default_nettype none
// ============================================================================
// diff_lag_sat : y[n] = x[n] - x[n-L] over a burst sample stream, saturated.
// Revision     : 1.0
// ============================================================================
module diff_lag_sat #(
  parameter int SAMPLE_W  = 16,
  parameter int BURST_LEN = 8,
  parameter int LAG_MAX   = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [$clog2(LAG_MAX+1)-1:0]   i_lag,
  input  logic                           i_edge_mode,
  input  logic [BURST_LEN*SAMPLE_W-1:0]  i_data,
  input  logic                           i_valid,
  input  logic                           i_last,
  output logic                           o_ready,
  output logic [BURST_LEN*SAMPLE_W-1:0]  o_data,
  output logic                           o_valid,
  output logic                           o_last,
  output logic [BURST_LEN-1:0]           o_sat,
  input  logic                           i_ready
);

  localparam int                LAG_W     = $clog2(LAG_MAX+1);
  localparam int                EXT_N     = LAG_MAX + BURST_LEN;
  localparam logic [LAG_W-1:0]  C_LAG_MAX = LAG_W'(LAG_MAX);
  localparam logic [LAG_W-1:0]  C_LAG_ONE = LAG_W'(1);
  localparam logic [SAMPLE_W-1:0] C_SMAX  = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic [SAMPLE_W-1:0] C_SMIN  = {1'b1, {(SAMPLE_W-1){1'b0}}};

  logic w_en;
  logic w_accept;

  logic                       first_q;
  logic [LAG_W-1:0]           lag_q;
  logic [SAMPLE_W-1:0]        hist_q   [LAG_MAX];

  logic                       s1_valid_q;
  logic                       s1_last_q;
  logic [SAMPLE_W-1:0]        s1_x_q   [BURST_LEN];
  logic [SAMPLE_W-1:0]        s1_sub_q [BURST_LEN];

  logic                          o_valid_q;
  logic                          o_last_q;
  logic [BURST_LEN*SAMPLE_W-1:0] o_data_q;
  logic [BURST_LEN-1:0]          o_sat_q;

  logic [LAG_W-1:0]              w_lag_eff;
  logic [LAG_W-1:0]              w_lag_use;
  logic [SAMPLE_W-1:0]           w_edge;
  logic [SAMPLE_W-1:0]           w_x      [BURST_LEN];
  logic [SAMPLE_W-1:0]           w_ext    [EXT_N];
  logic [SAMPLE_W-1:0]           w_sub    [BURST_LEN];
  logic [BURST_LEN*SAMPLE_W-1:0] data_d;
  logic [BURST_LEN-1:0]          sat_d;

  assign w_en     = !o_valid_q || i_ready;
  assign w_accept = i_valid && w_en;
  assign o_ready  = w_en;

  always_comb begin
    w_lag_eff = i_lag;
    if (i_lag == '0) begin
      w_lag_eff = C_LAG_ONE;
    end else if (i_lag > C_LAG_MAX) begin
      w_lag_eff = C_LAG_MAX;
    end
    w_lag_use = first_q ? w_lag_eff : lag_q;
  end

  assign w_edge = i_edge_mode ? w_x[0] : '0;

  // w_ext is the serial stream window: LAG_MAX history samples then the current beat.
  generate
    for (genvar k = 0; k < BURST_LEN; k++) begin : g_lane
      assign w_x[k]           = i_data[k*SAMPLE_W +: SAMPLE_W];
      assign w_ext[LAG_MAX+k] = w_x[k];
    end
    for (genvar j = 0; j < LAG_MAX; j++) begin : g_hist
      assign w_ext[j] = first_q ? w_edge : hist_q[j];
    end
  endgenerate

  always_comb begin
    for (int k = 0; k < BURST_LEN; k++) begin
      w_sub[k] = w_ext[LAG_MAX+k-1];
      for (int l = 2; l <= LAG_MAX; l++) begin
        if (w_lag_use == LAG_W'(l)) begin
          w_sub[k] = w_ext[LAG_MAX+k-l];
        end
      end
    end
  end

  always_comb begin
    data_d = '0;
    sat_d  = '0;
    for (int k = 0; k < BURST_LEN; k++) begin
      logic [SAMPLE_W:0] diff;
      diff = {s1_x_q[k][SAMPLE_W-1], s1_x_q[k]} - {s1_sub_q[k][SAMPLE_W-1], s1_sub_q[k]};
      if (diff[SAMPLE_W] != diff[SAMPLE_W-1]) begin
        sat_d[k] = 1'b1;
        data_d[k*SAMPLE_W +: SAMPLE_W] = diff[SAMPLE_W] ? C_SMIN : C_SMAX;
      end else begin
        data_d[k*SAMPLE_W +: SAMPLE_W] = diff[SAMPLE_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_q    <= 1'b1;
      lag_q      <= C_LAG_ONE;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      o_valid_q  <= 1'b0;
      o_last_q   <= 1'b0;
      o_data_q   <= '0;
      o_sat_q    <= '0;
      for (int j = 0; j < LAG_MAX; j++) begin
        hist_q[j] <= '0;
      end
      for (int k = 0; k < BURST_LEN; k++) begin
        s1_x_q[k]   <= '0;
        s1_sub_q[k] <= '0;
      end
    end else begin
      if (w_accept) begin
        first_q <= i_last;
        if (first_q) begin
          lag_q <= w_lag_eff;
        end
        for (int j = 0; j < LAG_MAX; j++) begin
          hist_q[j] <= w_x[BURST_LEN-LAG_MAX+j];
        end
      end
      if (w_en) begin
        s1_valid_q <= i_valid;
        s1_last_q  <= i_valid && i_last;
        s1_x_q     <= w_x;
        s1_sub_q   <= w_sub;
        o_valid_q  <= s1_valid_q;
        o_last_q   <= s1_last_q;
        o_data_q   <= data_d;
        o_sat_q    <= sat_d;
      end
    end
  end

  assign o_valid = o_valid_q;
  assign o_last  = o_last_q;
  assign o_data  = o_data_q;
  assign o_sat   = o_sat_q;

endmodule
`default_nettype wire

// File: tb/tb_diff_lag_sat.sv
`default_nettype none
// ============================================================================
// tb_diff_lag_sat : directed vectors, queue scoreboard and output monitor.
// Revision        : 1.0
// ============================================================================
module tb_diff_lag_sat;

  localparam int SW = 16;
  localparam int BL = 8;
  localparam int W  = SW * BL;

  typedef struct packed {
    logic [W-1:0]  d;
    logic          last;
    logic [BL-1:0] sat;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2:0]    i_lag;
  logic          i_edge_mode;
  logic [W-1:0]  i_data;
  logic          i_valid;
  logic          i_last;
  logic          o_ready;
  logic [W-1:0]  o_data;
  logic          o_valid;
  logic          o_last;
  logic [BL-1:0] o_sat;
  logic          i_ready;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  diff_lag_sat #(.SAMPLE_W(SW), .BURST_LEN(BL), .LAG_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n), .i_lag(i_lag), .i_edge_mode(i_edge_mode),
    .i_data(i_data), .i_valid(i_valid), .i_last(i_last), .o_ready(o_ready),
    .o_data(o_data), .o_valid(o_valid), .o_last(o_last), .o_sat(o_sat),
    .i_ready(i_ready)
  );

  function automatic logic [W-1:0] pk(input int v0, input int v1, input int v2, input int v3,
                                      input int v4, input int v5, input int v6, input int v7);
    logic [W-1:0] r;
    r = {SW'(v7), SW'(v6), SW'(v5), SW'(v4), SW'(v3), SW'(v2), SW'(v1), SW'(v0)};
    return r;
  endfunction

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic send(input logic [W-1:0] d, input bit last, input int lag, input bit edge_m,
                      input logic [W-1:0] exp_d, input logic [BL-1:0] exp_sat);
    bit ok;
    int t;
    exp_q.push_back('{d: exp_d, last: last, sat: exp_sat});
    i_data      = d;
    i_last      = last;
    i_lag       = 3'(lag);
    i_edge_mode = edge_m;
    i_valid     = 1'b1;
    ok = 1'b0;
    t  = 0;
    while (!ok) begin
      @(negedge clk);
      ok = o_ready;
      @(posedge clk);
      #1;
      if (!ok) begin
        t++;
        if (t > 50) begin
          n_vec++;
          n_fail++;
          $display("FAIL send_timeout got=o_ready_low want=accept");
          break;
        end
      end
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  // Monitor: pops one expectation per output handshake, and checks hold stability.
  initial begin : mon
    exp_t          e;
    bit            prev_hold = 1'b0;
    logic [W-1:0]  pd;
    logic          pl;
    logic [BL-1:0] ps;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          n_vec++;
          if (!o_valid || o_data !== pd || o_last !== pl || o_sat !== ps) begin
            n_fail++;
            $display("FAIL hold_stable got=%h/%b/%b/%b want=%h/1/%b/%b",
                     o_data, o_valid, o_last, o_sat, pd, pl, ps);
          end
        end
        if (o_valid && i_ready) begin
          n_vec++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_beat got=%h want=none", o_data);
          end else begin
            e = exp_q.pop_front();
            if (o_data !== e.d || o_last !== e.last || o_sat !== e.sat) begin
              n_fail++;
              $display("FAIL out_beat got d=%h last=%b sat=%b want d=%h last=%b sat=%b",
                       o_data, o_last, o_sat, e.d, e.last, e.sat);
            end
          end
        end
        prev_hold = o_valid && !i_ready;
        pd = o_data;
        pl = o_last;
        ps = o_sat;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int t;
    rst_n = 1'b0; i_ready = 1'b1; i_valid = 1'b0; i_last = 1'b0;
    i_lag = 3'd1; i_edge_mode = 1'b0; i_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_o_valid", W'(o_valid), '0);
    check("rst_o_last",  W'(o_last),  '0);
    check("rst_o_data",  o_data,      '0);
    check("rst_o_sat",   W'(o_sat),   '0);
    check("rst_o_ready", W'(o_ready), W'(1));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // L=1, zero edge, single-beat frame
    send(pk(1,2,3,4,5,6,7,8), 1, 1, 0, pk(1,1,1,1,1,1,1,1), '0);
    // L=2, replicate edge, two beats with bubbles between them
    send(pk(10,20,30,40,50,60,70,80), 0, 2, 1, pk(0,10,20,20,20,20,20,20), '0);
    repeat (3) @(posedge clk); #1;
    send(pk(90,100,110,120,130,140,150,160), 1, 2, 1, pk(20,20,20,20,20,20,20,20), '0);
    // saturation both directions
    send(pk(-32768,32767,0,0,0,0,0,0), 1, 1, 0, pk(-32768,32767,-32767,0,0,0,0,0), 8'b0000_0010);
    send(pk(32767,-32768,0,0,0,0,0,0), 1, 1, 0, pk(32767,-32768,32767,0,0,0,0,0), 8'b0000_0110);
    // lag change mid-frame is ignored until the next frame
    send(pk(0,1,4,9,16,25,36,49), 0, 1, 0, pk(0,1,3,5,7,9,11,13), '0);
    send(pk(64,81,100,121,144,169,196,225), 1, 3, 0, pk(15,17,19,21,23,25,27,29), '0);
    send(pk(0,1,4,9,16,25,36,49), 1, 3, 0, pk(0,1,4,9,15,21,27,33), '0);
    // lag clamps: 7 -> 4, 0 -> 1
    send(pk(100,200,300,400,500,600,700,800), 1, 7, 1, pk(0,100,200,300,400,400,400,400), '0);
    send(pk(5,6,8,11,15,20,26,33), 1, 0, 1, pk(0,1,2,3,4,5,6,7), '0);

    // downstream stall for 5 cycles with 3 beats offered
    fork
      begin
        send(pk(1,2,3,4,5,6,7,8), 0, 1, 0, pk(1,1,1,1,1,1,1,1), '0);
        send(pk(10,20,30,40,50,60,70,80), 0, 1, 0, pk(2,10,10,10,10,10,10,10), '0);
        send(pk(100,200,300,400,500,600,700,800), 1, 1, 0,
             pk(20,100,100,100,100,100,100,100), '0);
      end
      begin
        i_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("stall_o_ready", W'(o_ready), '0);
        repeat (2) @(posedge clk);
        #1 i_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk); #1;

    // asynchronous reset while an output beat is held
    i_ready = 1'b0;
    send(pk(50,40,30,20,10,0,-10,-20), 0, 2, 1, pk(0,-10,-20,-20,-20,-20,-20,-20), '0);
    send(pk(0,0,0,0,0,0,0,0), 0, 2, 1, pk(10,20,0,0,0,0,0,0), '0);
    @(negedge clk);
    check("pre_rst_valid", W'(o_valid), W'(1));
    check("pre_rst_data", o_data, pk(0,-10,-20,-20,-20,-20,-20,-20));
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", W'(o_valid), '0);
    check("async_rst_data",  o_data,      '0);
    check("async_rst_sat",   W'(o_sat),   '0);
    check("async_rst_ready", W'(o_ready), W'(1));
    exp_q.delete();
    @(negedge clk);
    #3 rst_n = 1'b1;
    i_ready = 1'b1;
    @(posedge clk); #1;
    send(pk(50,40,30,20,10,0,-10,-20), 1, 1, 1, pk(0,-10,-10,-10,-10,-10,-10,-10), '0);

    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got=%0d pending want=0", exp_q.size());
    end
    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
